// File: rtl/overflow_logger_pkg.sv
// Shared widths and helpers for the overflow event logger.
package overflow_logger_pkg;

  localparam int NB_DATA_DEF = 3;
  localparam int NB_TS_DEF   = 8;
  localparam int DEPTH_DEF   = 4;
  localparam int COUNT_W     = 8;

  // Saturating increment used by the event counter.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == {COUNT_W{1'b1}}) ? v : v + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; pointers carry one extra bit to tell full from empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // A push into a full FIFO is accepted only when the head leaves on the same edge.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    rdata    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/overflow_logger.sv
// Logs rising edges of an adder overflow flag with the accumulator value and a timestamp.
// Handshake: an entry transfers at a rising edge where o_valid and i_ready are both 1; o_valid never depends on i_ready.
module overflow_logger
  import overflow_logger_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_TS   = NB_TS_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [2*NB_DATA-1:0] i_data,
  input  logic                 i_overflow,
  input  logic                 i_clr,
  input  logic                 i_ready,
  output logic                 o_valid,
  output logic [2*NB_DATA-1:0] o_data,
  output logic [NB_TS-1:0]     o_ts,
  output logic [COUNT_W-1:0]   o_count,
  output logic                 o_drop,
  output logic                 o_full,
  output logic                 o_empty
);

  localparam int DW = 2 * NB_DATA;
  localparam int EW = DW + NB_TS;

  logic               ovf_prev_q, ovf_prev_d;
  logic [NB_TS-1:0]   ts_q, ts_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               drop_q, drop_d;
  logic               evt, pop_req, lost;
  logic               fifo_full, fifo_empty;
  logic [EW-1:0]      head;

  always_comb begin
    ovf_prev_d = i_overflow;
    ts_d       = ts_q + NB_TS'(1);
    evt        = i_overflow && !ovf_prev_q;
    pop_req    = !fifo_empty && i_ready;
    lost       = evt && fifo_full && !pop_req;
    count_d    = count_q;
    drop_d     = drop_q;
    // A clear restarts the statistics but still records this cycle's event.
    if (i_clr) begin
      count_d = evt ? COUNT_W'(1) : '0;
      drop_d  = lost;
    end else begin
      if (evt) count_d = sat_inc(count_q);
      if (lost) drop_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovf_prev_q <= 1'b0;
      ts_q       <= '0;
      count_q    <= '0;
      drop_q     <= 1'b0;
    end else begin
      ovf_prev_q <= ovf_prev_d;
      ts_q       <= ts_d;
      count_q    <= count_d;
      drop_q     <= drop_d;
    end
  end

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (evt),
    .pop   (pop_req),
    .wdata ({i_data, ts_q}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign o_valid = !fifo_empty;
  assign o_data  = head[EW-1:NB_TS];
  assign o_ts    = head[NB_TS-1:0];
  assign o_count = count_q;
  assign o_drop  = drop_q;
  assign o_full  = fifo_full;
  assign o_empty = fifo_empty;

endmodule
